// File: rtl/slt_pkg.sv
// Shared definitions for the SLT binary-search self-check harness:
// FSM state encoding, comparator latency range and the offset-binary MSB mask helper.
package slt_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PROBE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_PROBE = S_PROBE,
        ST_WAIT  = S_WAIT,
        ST_DONE  = S_DONE
    } state_t;

    // Largest supported comparator latency; also sizes the wait counter.
    localparam int CMP_LAT_MAX = 3;

    // Sign-bit mask used to move between two's complement and offset-binary (n <= 64).
    function automatic logic [63:0] msb_mask(input int unsigned n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/slt_bsearch_step_ctr.sv
// Bit-index and comparator-latency counter for slt_bsearch.
// Produces the strobe at which cmp_lt is taken and flags the final bit.
module bsearch_step_ctr
    import slt_pkg::*;
#(
    parameter int N       = 32,
    parameter int CMP_LAT = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_probe,
    input  logic                  i_wait,
    output logic                  o_sample,
    output logic                  o_last_bit,
    output logic [$clog2(N)-1:0]  o_bit_idx
);

    localparam int IW = $clog2(N);
    localparam int WW = $clog2(CMP_LAT_MAX + 1);
    localparam logic [WW-1:0] WCNT_LOAD = (CMP_LAT > 0) ? WW'(CMP_LAT - 1) : '0;

    logic [IW-1:0] r_idx;
    logic [WW-1:0] r_wcnt;

    // Answer is taken straight from PROBE with no latency, else when the wait counter expires.
    always_comb begin
        o_sample   = (i_probe && (CMP_LAT == 0)) || (i_wait && (r_wcnt == '0));
        o_last_bit = (r_idx == '0);
        o_bit_idx  = r_idx;
    end

    // Bit index counts N-1 down to 0; wait counter reloads on each PROBE and counts down in WAIT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx  <= '0;
            r_wcnt <= '0;
        end else if (i_load) begin
            r_idx  <= IW'(N - 1);
            r_wcnt <= '0;
        end else begin
            if (i_probe && (CMP_LAT != 0))
                r_wcnt <= WCNT_LOAD;
            else if (i_wait && (r_wcnt != '0))
                r_wcnt <= r_wcnt - 1'b1;
            if (o_sample && !o_last_bit)
                r_idx <= r_idx - 1'b1;
        end
    end

endmodule

// File: rtl/slt_bsearch.sv
// SLT comparator initiator: rebuilds a signed key MSB-first by successive approximation,
// using only the less-than answers of an external comparator.
// Optional key/result check is built when SLT_BSEARCH_CHECK_EN is defined.
module slt_bsearch
    import slt_pkg::*;
#(
    parameter int N       = 32,
    parameter int CMP_LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] key,
    output logic [N-1:0] cmp_a,
    output logic [N-1:0] cmp_b,
    input  logic         cmp_lt,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         mismatch
);

    localparam int IW = $clog2(N);
    localparam logic [N-1:0] MSB = N'(msb_mask(N));
    localparam logic [N-1:0] ONE = N'(1);

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_key;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_cmp_b;
    logic [N-1:0]  r_result;
    logic          r_busy;
    logic          r_done;

    logic          w_accept;
    logic          w_sample;
    logic          w_last_bit;
    logic [IW-1:0] w_bit_idx;
    logic [N-1:0]  w_bit_mask;
    logic [N-1:0]  w_acc_next;

    assign w_accept = (r_state == ST_IDLE) && start;

    bsearch_step_ctr #(
        .N       (N),
        .CMP_LAT (CMP_LAT)
    ) u_step_ctr (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_accept),
        .i_probe    (r_state == ST_PROBE),
        .i_wait     (r_state == ST_WAIT),
        .o_sample   (w_sample),
        .o_last_bit (w_last_bit),
        .o_bit_idx  (w_bit_idx)
    );

    // Resolve the current bit: key below the probe keeps it clear, otherwise it is set.
    always_comb begin
        w_bit_mask = ONE << w_bit_idx;
        w_acc_next = cmp_lt ? r_acc : (r_acc | w_bit_mask);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_PROBE;
            ST_PROBE: begin
                if (w_sample)
                    w_state_next = w_last_bit ? ST_DONE : ST_PROBE;
                else
                    w_state_next = ST_WAIT;
            end
            ST_WAIT:  if (w_sample) w_state_next = w_last_bit ? ST_DONE : ST_PROBE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch key, accumulate bits, drive the next probe, publish result with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key    <= '0;
            r_acc    <= '0;
            r_cmp_b  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_key   <= key;
                r_acc   <= '0;
                r_cmp_b <= MSB ^ MSB;   // first trial is the MSB alone, i.e. signed zero
                r_busy  <= 1'b1;
            end else if (w_sample) begin
                r_acc <= w_acc_next;
                if (w_last_bit) begin
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_result <= w_acc_next ^ MSB;
                end else begin
                    r_cmp_b <= (w_acc_next | (w_bit_mask >> 1)) ^ MSB;
                end
            end
        end
    end

`ifdef SLT_BSEARCH_CHECK_EN
    logic r_mismatch;

    // Flag a comparator fault alongside done; cleared when a new search is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_mismatch <= 1'b0;
        else if (w_accept)
            r_mismatch <= 1'b0;
        else if (w_sample && w_last_bit)
            r_mismatch <= ((w_acc_next ^ MSB) != r_key);
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

    assign cmp_a  = r_key;
    assign cmp_b  = r_cmp_b;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_slt_bsearch.sv
// Directed bench for slt_bsearch: two instances (comparator latency 0 and 1) share stimulus,
// each paired with a behavioural SLT comparator of matching latency.
module tb_slt_bsearch;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] key = '0;
    logic        inv = 1'b0;

    logic [31:0] cmp_a0, cmp_b0, result0, cmp_a1, cmp_b1, result1;
    logic        cmp_lt0, cmp_lt1, busy0, busy1, done0, done1, mm0, mm1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Comparators: latency 0 is combinational, latency 1 is one register stage.
    assign cmp_lt0 = ($signed(cmp_a0) < $signed(cmp_b0)) ^ inv;
    always @(posedge clk) cmp_lt1 <= ($signed(cmp_a1) < $signed(cmp_b1)) ^ inv;

    slt_bsearch #(.N(N), .CMP_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .key(key),
        .cmp_a(cmp_a0), .cmp_b(cmp_b0), .cmp_lt(cmp_lt0),
        .busy(busy0), .done(done0), .result(result0), .mismatch(mm0)
    );

    slt_bsearch #(.N(N), .CMP_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .key(key),
        .cmp_a(cmp_a1), .cmp_b(cmp_b1), .cmp_lt(cmp_lt1),
        .busy(busy1), .done(done1), .result(result1), .mismatch(mm1)
    );

`ifdef SLT_BSEARCH_CHECK_EN
    localparam logic EXP_MM_FAULT = 1'b1;
`else
    localparam logic EXP_MM_FAULT = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the accepting edge E0.
    task automatic do_start(input logic [31:0] k);
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_key(input string tag, input logic [31:0] k,
                           input logic [31:0] exp_res, input logic exp_mm);
        logic        got0, got1, mmv0, mmv1;
        logic [31:0] res0, res1;
        got0 = 1'b0; got1 = 1'b0; mmv0 = 1'b0; mmv1 = 1'b0; res0 = '0; res1 = '0;
        do_start(k);
        check({tag, "_probe0"}, cmp_b0, 32'h0);
        check({tag, "_probe1"}, cmp_b1, 32'h0);
        check({tag, "_cmpa0"}, cmp_a0, k);
        for (int c = 0; c < 100; c++) begin
            tick();
            if (done0 && !got0) begin got0 = 1'b1; res0 = result0; mmv0 = mm0; end
            if (done1 && !got1) begin got1 = 1'b1; res1 = result1; mmv1 = mm1; end
        end
        check({tag, "_done0"}, {31'b0, got0}, 32'd1);
        check({tag, "_done1"}, {31'b0, got1}, 32'd1);
        check({tag, "_res0"}, res0, exp_res);
        check({tag, "_res1"}, res1, exp_res);
        check({tag, "_mm0"}, {31'b0, mmv0}, {31'b0, exp_mm});
        check({tag, "_mm1"}, {31'b0, mmv1}, {31'b0, exp_mm});
    endtask

    initial begin
        int d0_edge, d1_edge, d0_cnt, d1_cnt, b0_at_done;

        // Reset values
        #1;
        check("rst_busy0", {31'b0, busy0}, 32'd0);
        check("rst_done1", {31'b0, done1}, 32'd0);
        check("rst_cmpb0", cmp_b0, 32'h0);
        check("rst_result1", result1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // key=10 with latency check and an ignored second start at E0+5 carrying key=4
        d0_edge = 0; d1_edge = 0; d0_cnt = 0; d1_cnt = 0; b0_at_done = 1;
        do_start(32'd10);
        check("k10_busy0", {31'b0, busy0}, 32'd1);
        check("k10_busy1", {31'b0, busy1}, 32'd1);
        check("k10_probe0", cmp_b0, 32'h0);
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (done0) begin d0_cnt++; if (d0_edge == 0) begin d0_edge = k + 1; b0_at_done = int'(busy0); end end
            if (done1) begin d1_cnt++; if (d1_edge == 0) d1_edge = k + 1; end
            if (k == 4) begin key = 32'd4; start = 1'b1; end
            if (k == 5) start = 1'b0;
        end
        check("k10_lat0", d0_edge, 32'd33);
        check("k10_lat1", d1_edge, 32'd65);
        check("k10_pulses0", d0_cnt, 32'd1);
        check("k10_pulses1", d1_cnt, 32'd1);
        check("k10_busy_at_done", b0_at_done, 32'd0);
        check("k10_res0", result0, 32'd10);
        check("k10_res1", result1, 32'd10);
        check("k10_mm0", {31'b0, mm0}, 32'd0);

        // Signed values and boundaries
        run_key("neg8", 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0);
        run_key("zero", 32'h0, 32'h0, 1'b0);
        run_key("minneg", 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_key("maxpos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        run_key("k3039", 32'h0000_3039, 32'h0000_3039, 1'b0);

        // Reset in the middle of a search
        do_start(32'd10);
        repeat (11) tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_busy0", {31'b0, busy0}, 32'd0);
        check("mrst_busy1", {31'b0, busy1}, 32'd0);
        check("mrst_cmpa0", cmp_a0, 32'h0);
        check("mrst_cmpb1", cmp_b1, 32'h0);
        check("mrst_res0", result0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        d0_cnt = 0; d1_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (done0) d0_cnt++;
            if (done1) d1_cnt++;
        end
        check("mrst_nodone0", d0_cnt, 32'd0);
        check("mrst_nodone1", d1_cnt, 32'd0);
        check("mrst_res1", result1, 32'h0);
        run_key("after_rst", 32'd10, 32'd10, 1'b0);

        // Faulty (inverted) comparator: every answer says key < probe, so acc stays 0
        inv = 1'b1;
        run_key("inv", 32'd10, 32'h8000_0000, EXP_MM_FAULT);
        inv = 1'b0;
        run_key("recover", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
